// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg
//   Shared definitions for the product accumulator slice: the two-state
//   frame FSM encoding and the default widths used as parameter defaults.
package prod_acc_pkg;

   localparam int PW_DEF    = 64;   // product width (multiplier p)
   localparam int ACC_W_DEF = 72;   // accumulator width, >= PW
   localparam int CNT_W_DEF = 8;    // beat counter width

   typedef enum logic {
      ACCUM = 1'b0,   // taking product beats
      HOLD  = 1'b1    // frame result presented, waiting for drain
   } state_t;

endpackage

// File: rtl/prod_accumulator_if.sv
// prod_accumulator_if
//   Groups the product-input handshake and the result-output handshake.
//   slave  : accumulator view (consumes products, produces results)
//   master : environment view (multiplier side + result consumer)
//   Signals: p_valid/p_ready/p_data/p_last/flush   product beats
//            acc_valid/acc_ready/acc_data/acc_count/acc_ovf   frame result
interface prod_accumulator_if
   import prod_acc_pkg::*;
#(
   parameter int PW    = PW_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);

   logic             p_valid;
   logic             p_ready;
   logic [PW-1:0]    p_data;
   logic             p_last;
   logic             flush;
   logic             acc_valid;
   logic             acc_ready;
   logic [ACC_W-1:0] acc_data;
   logic [CNT_W-1:0] acc_count;
   logic             acc_ovf;

   modport slave (
      input  p_valid, p_data, p_last, flush, acc_ready,
      output p_ready, acc_valid, acc_data, acc_count, acc_ovf
   );

   modport master (
      output p_valid, p_data, p_last, flush, acc_ready,
      input  p_ready, acc_valid, acc_data, acc_count, acc_ovf
   );

endinterface

// File: rtl/prod_acc_datapath.sv
// prod_acc_datapath
//   Wide accumulator and saturating beat counter.
//   clk    : clock
//   clear  : zero sum and count (takes priority over enable)
//   enable : add data into sum and bump count
//   data   : unsigned product, zero-extended into the sum
//   sum    : registered running sum (wraps on carry-out)
//   count  : registered beat count (sticks at all-ones)
//   carry  : carry-out of sum + data this cycle (combinational)
//   sat    : count is already all-ones (combinational)
module prod_acc_datapath
   import prod_acc_pkg::*;
#(
   parameter int PW    = PW_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   input  logic [PW-1:0]    data,
   output logic [ACC_W-1:0] sum,
   output logic [CNT_W-1:0] count,
   output logic             carry,
   output logic             sat
);

   logic [ACC_W:0] sum_ext;

   // One extra bit on the adder exposes the carry-out beyond ACC_W.
   assign sum_ext = {1'b0, sum} + {{(ACC_W + 1 - PW){1'b0}}, data};
   assign carry   = sum_ext[ACC_W];
   assign sat     = &count;

   always_ff @(posedge clk) begin
      if (clear) begin
         sum   <= '0;
         count <= '0;
      end else if (enable) begin
         sum <= sum_ext[ACC_W-1:0];
         if (!sat) begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/prod_accumulator.sv
// prod_accumulator
//   Sums one frame of 64-bit unsigned products and holds the frame total,
//   beat count and sticky overflow until a consumer drains it.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; discards any partial frame
//   bus : prod_accumulator_if.slave
//         p_valid/p_ready/p_data/p_last/flush  product beats in
//         acc_valid/acc_ready/acc_data/acc_count/acc_ovf  frame result out
module prod_accumulator
   import prod_acc_pkg::*;
#(
   parameter int PW    = PW_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   prod_accumulator_if.slave     bus
);

   state_t           state_q;
   state_t           state_d;
   logic             accept;
   logic             close;
   logic             drain;
   logic             dp_clear;
   logic             ovf_q;
   logic [ACC_W-1:0] sum;
   logic [CNT_W-1:0] count;
   logic             carry;
   logic             sat;

   // Handshake outputs depend only on state and rst, never on p_valid.
   assign bus.p_ready   = (state_q == ACCUM) && !rst;
   assign bus.acc_valid = (state_q == HOLD) && !rst;

   assign accept   = bus.p_valid && bus.p_ready;
   assign drain    = (state_q == HOLD) && bus.acc_ready;
   // Draining and reset both start a fresh frame from zero.
   assign dp_clear = rst || drain;

   prod_acc_datapath #(
      .PW    (PW),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_datapath (
      .clk    (clk),
      .clear  (dp_clear),
      .enable (accept),
      .data   (bus.p_data),
      .sum    (sum),
      .count  (count),
      .carry  (carry),
      .sat    (sat)
   );

   always_comb begin
      state_d = state_q;
      close   = 1'b0;
      case (state_q)
         ACCUM: begin
            // A flush closes the frame only if it would carry at least one
            // beat: either one already counted or one accepted this cycle.
            close = (accept && bus.p_last) ||
                    (bus.flush && bus.p_ready && (accept || (count != '0)));
            if (close) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.acc_ready) begin
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Sticky overflow: a lost carry or a beat arriving with the count
   // already pinned at all-ones.
   always_ff @(posedge clk) begin
      if (dp_clear) begin
         ovf_q <= 1'b0;
      end else if (accept && (carry || sat)) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.acc_data  = sum;
   assign bus.acc_count = count;
   assign bus.acc_ovf   = ovf_q;

endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

Downstream stage of the 32x32 unsigned multiplier `signbit32`. It consumes the 64-bit products through a valid/ready handshake and sums one frame of products into a wide accumulator. It presents the frame total, beat count and an overflow flag as a held result that a consumer drains with its own valid/ready handshake. The block turns the combinational multiplier into a sum-of-products engine for dot-product and MAC workloads.

## Interface
- `PW`, 64: product width; matches multiplier `p`.
- `ACC_W`, 72: accumulator width; must be at least `PW`.
- `CNT_W`, 8: beat-counter width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `p_valid` input 1: product beat valid.
- `p_ready` output 1: block accepts a beat.
- `p_data` input PW: unsigned product from multiplier `p`.
- `p_last` input 1: this beat closes the frame.
- `flush` input 1: close the frame now. Qualified only when `p_ready`=1.
- `acc_valid` output 1: result held and valid.
- `acc_ready` input 1: consumer takes the result.
- `acc_data` output ACC_W: frame sum.
- `acc_count` output CNT_W: beats in the frame.
- `acc_ovf` output 1: sticky; set by sum carry-out or count saturation within the frame.

## Operation
- Two states:
  - ACCUM: `p_ready`=1, `acc_valid`=0.
  - HOLD: `p_ready`=0, `acc_valid`=1.
- `p_ready` = (state==ACCUM) && !`rst`.
- Beat accept is `p_valid` && `p_ready`. On accept:
  - acc <= acc + zero-extend(`p_data`).
  - count <= count+1.
- Sum carry-out beyond ACC_W: the wrapped sum is kept and ovf sets sticky.
- Count at all-ones: count saturates and ovf sets.
- ACCUM -> HOLD when any of the following holds:
  - An accept occurs with `p_last`=1. The result includes that beat.
  - `flush`=1 with count>0. If a beat is accepted in the same cycle, it is included.
- `flush`=1 with count=0 and no accept is ignored; no empty frame is emitted.
- `flush` and `p_last` in the same cycle produce one frame.
- HOLD: `acc_data`/`acc_count`/`acc_ovf` are registered and stable. `p_valid`/`p_data` are ignored.
- HOLD -> ACCUM when `acc_ready`=1. In the same edge, acc, count and ovf clear to 0.
- `acc_ready` outside HOLD has no effect.
- Reset, including mid-frame or in HOLD:
  - State goes to ACCUM; acc, count and ovf go to 0.
  - `acc_valid`=0 and `p_ready`=0 while `rst` is high.
  - `p_ready`=1 on the first cycle after `rst` deasserts.
  - Any partial frame is discarded.

## Timing
- Accept-to-result latency: `acc_valid` rises on the cycle after the accepted `p_last` or qualifying `flush`.
- Result drain: one cycle minimum with `acc_ready` tied high. The next frame's first beat is accepted on the cycle after the HOLD->ACCUM edge.
- Throughput: one beat per cycle inside a frame, plus one bubble cycle per frame (the HOLD cycle).
- No combinational path from `p_valid` to `p_ready`. `acc_valid` is registered state. `p_ready` depends only on state and `rst`.
- `p_data` is sampled only on the accept edge. The multiplier output may settle anywhere within the cycle.

## Structure
- Shared package `prod_acc_pkg`:
  - State enum ACCUM/HOLD.
  - Default constants PW=64, ACC_W=72, CNT_W=8.
- One sub-module, `prod_acc_datapath`, holds the ACC_W adder and the saturating counter.
  - Inputs: clear, enable, data.
  - Outputs: sum, count, carry, sat.
- The top level holds the FSM, the handshake and the ovf register.

## Test plan
- Reset, then beats 48 (12x4) and 12 (3x4, `p_last`=1), `acc_ready`=0 -> `acc_valid`=1 next cycle. Result held: `acc_data`=60, `acc_count`=2, `acc_ovf`=0, `p_ready`=0 until `acc_ready`=1.
- Back-to-back frames {5,7 last} and {9 last}, `acc_ready`=1 -> results 12/2, then 9/1. Exactly one bubble cycle with `p_ready`=0 per frame.
- Beats 2^64-1 x 257 with `ACC_W`=72 -> `acc_data`=(257·(2^64−1)) mod 2^72, `acc_ovf`=1 (carry out of bit 71 on beat 257); `acc_count`=255 saturated. The next frame, {1 last}, gives `acc_ovf`=0.
- Beats 10, 20, then `flush`=1 with no beat -> `acc_data`=30, count 2. `flush` alone in an empty ACCUM -> no `acc_valid`. `flush` with beat 4 in the same cycle -> `acc_data`=4, count 1.
- `p_valid` held high with data 99 during HOLD -> not accepted; the HOLD result is unchanged; 99 is accepted only after drain.
- `rst` asserted after beats 3, 4 (mid-frame), then frame {6 last} -> `acc_data`=6, count 1. `rst` in HOLD -> `acc_valid`=0 next cycle; `p_ready`=1 the cycle after `rst` drops.
